// File: rtl/dev_dip_in.sv
// Operator input device: synchronizes and debounces the DIP-switch bank and push button,
// and hands the switch byte captured on each debounced press to the core over valid/ready.
module dev_dip_in #(
    parameter int DEBOUNCE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] dip_pins,
    input  logic       btn_pin,
    output logic [7:0] dip_now,
    output logic [7:0] val,
    output logic       valid,
    input  logic       ready,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btnState_t;

    logic [7:0]       r_dipSync1;
    logic [7:0]       r_dipS;
    logic             r_btnSync1;
    logic             r_btnS;
    logic [7:0]       r_dipNow;
    logic [CNT_W-1:0] r_dipCnt;
    btnState_t        r_state;
    logic [CNT_W-1:0] r_btnCnt;
    logic [7:0]       r_val;
    logic             r_valid;
    logic             r_overrun;

    btnState_t        w_stateNext;
    logic [CNT_W-1:0] w_btnCntNext;
    logic             w_capture;
    logic             w_dipRestart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dipSync1 <= '0;
            r_dipS     <= '0;
            r_btnSync1 <= 1'b0;
            r_btnS     <= 1'b0;
        end else begin
            r_dipSync1 <= dip_pins;
            r_dipS     <= r_dipSync1;
            r_btnSync1 <= btn_pin;
            r_btnS     <= r_btnSync1;
        end
    end

    // Restart when dip_s is about to take a new value, so the count measures how long it has been stable.
    assign w_dipRestart = (r_dipSync1 != r_dipS) || (r_dipS == r_dipNow);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dipCnt <= '0;
            r_dipNow <= '0;
        end else if (w_dipRestart) begin
            r_dipCnt <= '0;
        end else if (en) begin
            if (r_dipCnt == LP_LAST) begin
                r_dipNow <= r_dipS;
                r_dipCnt <= '0;
            end else begin
                r_dipCnt <= r_dipCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RELEASED;
            r_btnCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_btnCnt <= w_btnCntNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_btnCntNext = r_btnCnt;
        w_capture    = 1'b0;
        if (en) begin
            case (r_state)
                RELEASED: begin
                    if (r_btnS) begin
                        w_stateNext  = PRESS_WAIT;
                        w_btnCntNext = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!r_btnS) begin
                        w_stateNext  = RELEASED;
                        w_btnCntNext = '0;
                    end else if (r_btnCnt == LP_LAST) begin
                        w_stateNext  = PRESSED;
                        w_btnCntNext = '0;
                        w_capture    = 1'b1;
                    end else begin
                        w_btnCntNext = r_btnCnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!r_btnS) begin
                        w_stateNext  = RELEASE_WAIT;
                        w_btnCntNext = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (r_btnS) begin
                        w_stateNext  = PRESSED;
                        w_btnCntNext = '0;
                    end else if (r_btnCnt == LP_LAST) begin
                        w_stateNext  = RELEASED;
                        w_btnCntNext = '0;
                    end else begin
                        w_btnCntNext = r_btnCnt + 1'b1;
                    end
                end
                default: begin
                    w_stateNext  = RELEASED;
                    w_btnCntNext = '0;
                end
            endcase
        end
    end

    // A capture that lands while the previous byte is still unaccepted is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            if (!r_valid || ready) begin
                r_val   <= r_dipNow;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dip_now = r_dipNow;
    assign val     = r_val;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_dev_dip_in.sv
// Directed bench for dev_dip_in with DEBOUNCE=4; expected values are hand-derived edge counts.
module tb_dev_dip_in;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] dip_pins;
    logic       btn_pin;
    logic [7:0] dip_now;
    logic [7:0] val;
    logic       valid;
    logic       ready;
    logic       overrun;

    int checks = 0;
    int passes = 0;

    dev_dip_in #(.DEBOUNCE(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .dip_pins(dip_pins), .btn_pin(btn_pin),
        .dip_now(dip_now), .val(val), .valid(valid), .ready(ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit so outputs are stable and new inputs land before the next edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic releaseButton();
        btn_pin = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ready = 1'b0;
        dip_pins = 8'hFF; btn_pin = 1'b1;
        tick(1);
        dip_pins = 8'h00; btn_pin = 1'b0;
        tick(1);
        rst = 1'b0;
        checks++; if (val !== 8'h00) $display("[TB] FAIL reset_val: got %h want 00", val); else passes++;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b want 0", overrun); else passes++;
        checks++; if (dip_now !== 8'h00) $display("[TB] FAIL reset_dip_now: got %h want 00", dip_now); else passes++;
        tick(4);
    endtask

    task automatic test_basic_capture();
        dip_pins = 8'hA5;
        tick(5);
        checks++; if (dip_now !== 8'h00) $display("[TB] FAIL basic_dip_early: got %h want 00", dip_now); else passes++;
        tick(1);
        checks++; if (dip_now !== 8'hA5) $display("[TB] FAIL basic_dip_now: got %h want A5", dip_now); else passes++;
        btn_pin = 1'b1;
        tick(5);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL basic_valid_early: got %b want 0", valid); else passes++;
        tick(1);
        checks++; if (valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b want 1", valid); else passes++;
        checks++; if (val !== 8'hA5) $display("[TB] FAIL basic_val: got %h want A5", val); else passes++;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL basic_accept: got %b want 0", valid); else passes++;
        releaseButton();
        checks++; if (valid !== 1'b0) $display("[TB] FAIL basic_release: got %b want 0", valid); else passes++;
    endtask

    task automatic test_glitch();
        btn_pin = 1'b1;
        tick(3);
        btn_pin = 1'b0;
        tick(12);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL glitch_btn_valid: got %b want 0", valid); else passes++;
        // A full press after the glitch must see the normal latency, proving the FSM fell back to RELEASED.
        btn_pin = 1'b1;
        tick(5);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL glitch_relatch_early: got %b want 0", valid); else passes++;
        tick(1);
        checks++; if (valid !== 1'b1) $display("[TB] FAIL glitch_relatch_valid: got %b want 1", valid); else passes++;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        releaseButton();
        dip_pins = 8'h5A;
        tick(3);
        dip_pins = 8'hA5;
        tick(12);
        checks++; if (dip_now !== 8'hA5) $display("[TB] FAIL glitch_dip_now: got %h want A5", dip_now); else passes++;
    endtask

    task automatic test_held_button();
        btn_pin = 1'b1;
        tick(6);
        checks++; if (valid !== 1'b1) $display("[TB] FAIL held_first_valid: got %b want 1", valid); else passes++;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(15);
        btn_pin = 1'b0;
        tick(2);
        btn_pin = 1'b1;
        tick(26);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL held_second_capture: got %b want 0", valid); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL held_overrun: got %b want 0", overrun); else passes++;
        releaseButton();
    endtask

    task automatic test_overrun();
        dip_pins = 8'h3C;
        tick(6);
        checks++; if (dip_now !== 8'h3C) $display("[TB] FAIL ovr_dip_now: got %h want 3C", dip_now); else passes++;
        btn_pin = 1'b1;
        tick(6);
        checks++; if (val !== 8'h3C) $display("[TB] FAIL ovr_first_val: got %h want 3C", val); else passes++;
        dip_pins = 8'hC3;
        tick(6);
        releaseButton();
        btn_pin = 1'b1;
        tick(8);
        checks++; if (val !== 8'h3C) $display("[TB] FAIL ovr_val_held: got %h want 3C", val); else passes++;
        checks++; if (valid !== 1'b1) $display("[TB] FAIL ovr_valid: got %b want 1", valid); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b want 1", overrun); else passes++;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL ovr_accept_valid: got %b want 0", valid); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); else passes++;
        releaseButton();
    endtask

    task automatic test_en_gating();
        btn_pin = 1'b1;
        tick(3);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(2);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL en_valid_early: got %b want 0", valid); else passes++;
        tick(1);
        checks++; if (valid !== 1'b1) $display("[TB] FAIL en_valid: got %b want 1", valid); else passes++;
        checks++; if (val !== 8'hC3) $display("[TB] FAIL en_val: got %h want C3", val); else passes++;
        en = 1'b0;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        en = 1'b1;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL en_accept_disabled: got %b want 0", valid); else passes++;
        releaseButton();
    endtask

    task automatic test_mid_reset();
        btn_pin = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL rst_overrun: got %b want 0", overrun); else passes++;
        checks++; if (dip_now !== 8'h00) $display("[TB] FAIL rst_dip_now: got %h want 00", dip_now); else passes++;
        tick(5);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL rst_valid_early: got %b want 0", valid); else passes++;
        tick(1);
        checks++; if (valid !== 1'b1) $display("[TB] FAIL rst_valid: got %b want 1", valid); else passes++;
        // The capture edge is also the edge dip_now re-settles, so the captured byte is the pre-edge value.
        checks++; if (val !== 8'h00) $display("[TB] FAIL rst_val: got %h want 00", val); else passes++;
        checks++; if (dip_now !== 8'hC3) $display("[TB] FAIL rst_dip_resettle: got %h want C3", dip_now); else passes++;
        releaseButton();
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_glitch();
        test_held_button();
        test_overrun();
        test_en_gating();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
